// File: rtl/hyperbus_trans_splitter_pkg.sv
// Shared types, default parameters and address-decode helpers for the
// HyperBus transaction splitter.
package hyperbus_trans_splitter_pkg;

  localparam int DEF_BURST_WIDTH   = 12;
  localparam int DEF_NR_CS         = 2;
  localparam int DEF_MEM_SIZE_LOG2 = 23;
  localparam int DEF_MAX_BURST     = 256;
  localparam int DEF_LEN_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } split_state_t;

  // Word address inside the chip: drop the chip-select bits, then the byte bit.
  function automatic logic [31:0] word_addr(input logic [31:0] addr,
                                            input int unsigned mem_size_log2);
    logic [31:0] mask;
    mask = (32'd1 << mem_size_log2) - 32'd1;
    return (addr & mask) >> 1;
  endfunction

  // Chip index is everything above the per-chip byte range.
  function automatic logic [31:0] cs_index(input logic [31:0] addr,
                                           input int unsigned mem_size_log2);
    return addr >> mem_size_log2;
  endfunction

  // One-hot chip select; all zeros when the index is out of range.
  function automatic logic [31:0] cs_onehot(input logic [31:0] idx,
                                            input int unsigned nr_cs);
    logic [31:0] oh;
    oh = 32'd0;
    if (idx < nr_cs) begin
      oh = 32'd1 << idx;
    end else begin
      oh = 32'd0;
    end
    return oh;
  endfunction

endpackage

// File: rtl/hyperbus_trans_splitter_if.sv
// Request-side and PHY-side handshake bundle of the transaction splitter.
// slave: the splitter itself; master: the environment around it.
interface hyperbus_trans_splitter_if #(
  parameter int BURST_WIDTH = hyperbus_trans_splitter_pkg::DEF_BURST_WIDTH,
  parameter int NR_CS       = hyperbus_trans_splitter_pkg::DEF_NR_CS,
  parameter int LEN_WIDTH   = hyperbus_trans_splitter_pkg::DEF_LEN_WIDTH
);

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [31:0]            req_addr_i;
  logic [LEN_WIDTH-1:0]   req_len_i;
  logic                   req_write_i;
  logic                   trans_valid_o;
  logic                   trans_ready_i;
  logic [31:0]            trans_address_o;
  logic [NR_CS-1:0]       trans_cs_o;
  logic                   trans_write_o;
  logic [BURST_WIDTH-1:0] trans_burst_o;
  logic                   done_o;
  logic                   error_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_write_i, trans_ready_i,
    output req_ready_o, trans_valid_o, trans_address_o, trans_cs_o,
           trans_write_o, trans_burst_o, done_o, error_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_write_i, trans_ready_i,
    input  req_ready_o, trans_valid_o, trans_address_o, trans_cs_o,
           trans_write_o, trans_burst_o, done_o, error_o
  );

endinterface

// File: rtl/hyperbus_trans_splitter.sv
// HyperBus upstream command stage: splits one linear request into PHY
// transactions bounded by MAX_BURST, MAX_BURST-aligned word boundaries and
// chip boundaries, decoding the chip select of every chunk.
module hyperbus_trans_splitter
  import hyperbus_trans_splitter_pkg::*;
#(
  parameter int BURST_WIDTH   = DEF_BURST_WIDTH,
  parameter int NR_CS         = DEF_NR_CS,
  parameter int MEM_SIZE_LOG2 = DEF_MEM_SIZE_LOG2,
  parameter int MAX_BURST     = DEF_MAX_BURST,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  hyperbus_trans_splitter_if.slave bus
);

  split_state_t state_r, next_state_s;

  // Request context, advanced after each issued chunk.
  logic [31:0]            addr_r;
  logic [LEN_WIDTH-1:0]   rem_r;
  logic                   write_r;

  // Registered PHY-side and status outputs.
  logic                   trans_valid_r;
  logic [31:0]            trans_address_r;
  logic [NR_CS-1:0]       trans_cs_r;
  logic                   trans_write_r;
  logic [BURST_WIDTH-1:0] trans_burst_r;
  logic                   done_r;
  logic                   error_r;
  logic                   req_ready_r;

  logic                   accept_s;
  logic                   req_bad_s;
  logic                   fire_s;
  logic                   done_set_s;
  logic                   error_set_s;
  logic [31:0]            word_s;
  logic [31:0]            room_s;
  logic [BURST_WIDTH-1:0] chunk_s;
  logic [31:0]            addr_next_s;
  logic [LEN_WIDTH-1:0]   rem_next_s;

  assign accept_s    = (state_r == IDLE) & bus.req_valid_i;
  assign req_bad_s   = bus.req_addr_i[0] |
                       (cs_index(bus.req_addr_i, MEM_SIZE_LOG2) >= 32'(NR_CS));
  assign fire_s      = trans_valid_r & bus.trans_ready_i;
  assign rem_next_s  = rem_r - LEN_WIDTH'(trans_burst_r);
  assign addr_next_s = addr_r + (32'(trans_burst_r) << 1);

  // Chunk size: whatever is left, capped at the room up to the next aligned burst boundary.
  always_comb begin
    word_s = word_addr(addr_r, MEM_SIZE_LOG2);
    room_s = 32'(MAX_BURST) - (word_s & 32'(MAX_BURST - 1));
    if (32'(rem_r) < room_s) begin
      chunk_s = BURST_WIDTH'(rem_r);
    end else begin
      chunk_s = BURST_WIDTH'(room_s);
    end
  end

  // Next-state logic and one-cycle done/error requests.
  always_comb begin
    next_state_s = state_r;
    done_set_s   = 1'b0;
    error_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_bad_s) begin
            error_set_s = 1'b1;
          end else if (bus.req_len_i == {LEN_WIDTH{1'b0}}) begin
            done_set_s = 1'b1;
          end else begin
            next_state_s = CALC;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        next_state_s = ISSUE;
      end
      ISSUE: begin
        if (fire_s) begin
          if (rem_next_s == {LEN_WIDTH{1'b0}}) begin
            done_set_s   = 1'b1;
            next_state_s = IDLE;
          end else if (cs_index(addr_next_s, MEM_SIZE_LOG2) >= 32'(NR_CS)) begin
            // The advanced address ran off the last chip: drop the remainder.
            error_set_s  = 1'b1;
            next_state_s = IDLE;
          end else begin
            next_state_s = CALC;
          end
        end else begin
          next_state_s = ISSUE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register plus registered ready and status pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      req_ready_r <= (next_state_s == IDLE);
      done_r      <= done_set_s;
      error_r     <= error_set_s;
    end
  end

  // Latch the request on accept and advance it after each issued chunk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r  <= 32'd0;
      rem_r   <= {LEN_WIDTH{1'b0}};
      write_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= bus.req_addr_i;
      rem_r   <= bus.req_len_i;
      write_r <= bus.req_write_i;
    end else if (fire_s) begin
      addr_r  <= addr_next_s;
      rem_r   <= rem_next_s;
    end
  end

  // Load the PHY chunk in CALC and hold it until the PHY takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trans_valid_r   <= 1'b0;
      trans_address_r <= 32'd0;
      trans_cs_r      <= {NR_CS{1'b0}};
      trans_write_r   <= 1'b0;
      trans_burst_r   <= {BURST_WIDTH{1'b0}};
    end else if (state_r == CALC) begin
      trans_valid_r   <= 1'b1;
      trans_address_r <= word_s;
      trans_cs_r      <= NR_CS'(cs_onehot(cs_index(addr_r, MEM_SIZE_LOG2), NR_CS));
      trans_write_r   <= write_r;
      trans_burst_r   <= chunk_s;
    end else if (fire_s) begin
      trans_valid_r   <= 1'b0;
    end
  end

  assign bus.req_ready_o     = req_ready_r;
  assign bus.trans_valid_o   = trans_valid_r;
  assign bus.trans_address_o = trans_address_r;
  assign bus.trans_cs_o      = trans_cs_r;
  assign bus.trans_write_o   = trans_write_r;
  assign bus.trans_burst_o   = trans_burst_r;
  assign bus.done_o          = done_r;
  assign bus.error_o         = error_r;

endmodule

// File: tb/tb_hyperbus_trans_splitter.sv
// Self-checking bench for hyperbus_trans_splitter: a table of requests with
// hand-computed chunk lists fed through a scoreboard queue, plus sequences for
// backpressure and asynchronous reset in the middle of a transfer.
module tb_hyperbus_trans_splitter;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  cs;
    logic [11:0] burst;
    logic        wr;
  } chunk_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic        wr;
    int          n;
    chunk_t      ch [3];
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  chunk_t exp_q[$];
  vec_t   vq[$];

  always #5 clk = ~clk;

  hyperbus_trans_splitter_if bus ();

  hyperbus_trans_splitter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic chunk_t mk(input logic [31:0] w, input logic [1:0] cs,
                                input logic [11:0] b, input logic wr);
    chunk_t c;
    c.word = w; c.cs = cs; c.burst = b; c.wr = wr;
    return c;
  endfunction

  task automatic add_vec(input logic [31:0] a, input logic [15:0] l, input logic wr,
                         input int n, input logic err,
                         input chunk_t c0, input chunk_t c1, input chunk_t c2);
    vec_t v;
    v.addr = a; v.len = l; v.wr = wr; v.n = n; v.err = err;
    v.ch[0] = c0; v.ch[1] = c1; v.ch[2] = c2;
    vq.push_back(v);
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [15:0] l, input logic w);
    int g;
    g = 0;
    while (!bus.req_ready_o && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("req_ready_wait", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_len_i   = l;
    bus.req_write_i = w;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic compare_chunk(input chunk_t e);
    check("chunk_word",  bus.trans_address_o, e.word);
    check("chunk_cs",    32'(bus.trans_cs_o), 32'(e.cs));
    check("chunk_burst", 32'(bus.trans_burst_o), 32'(e.burst));
    check("chunk_write", 32'(bus.trans_write_o), 32'(e.wr));
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int first_valid;
    logic got_done;
    logic got_err;
    for (int j = 0; j < v.n; j++) exp_q.push_back(v.ch[j]);
    drive_req(v.addr, v.len, v.wr);
    if (v.n > 0) check("busy_ready", 32'(bus.req_ready_o), 32'd0);
    cyc = 1; first_valid = -1; got_done = 1'b0; got_err = 1'b0;
    while (!got_done && !got_err && cyc < 3000) begin
      if (bus.trans_valid_o && first_valid < 0) first_valid = cyc;
      check("done_err_excl", 32'(bus.done_o & bus.error_o), 32'd0);
      got_done = bus.done_o;
      got_err  = bus.error_o;
      if (bus.trans_valid_o && bus.trans_ready_i) begin
        if (exp_q.size() == 0) check("extra_chunk", 32'd1, 32'd0);
        else compare_chunk(exp_q.pop_front());
      end
      if (!got_done && !got_err) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("end_timeout", 32'(got_done | got_err), 32'd1);
    check("end_error", 32'(got_err), 32'(v.err));
    check("end_done", 32'(got_done), 32'(!v.err));
    if (v.n > 0) check("first_latency", 32'(first_valid), 32'd2);
    check("missing_chunks", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    check("pulse_done_low",  32'(bus.done_o), 32'd0);
    check("pulse_error_low", 32'(bus.error_o), 32'd0);
    check("idle_ready",      32'(bus.req_ready_o), 32'd1);
    check("idle_valid",      32'(bus.trans_valid_o), 32'd0);
  endtask

  initial begin
    chunk_t z;
    chunk_t snap;
    int g;
    z = mk(32'd0, 2'b00, 12'd0, 1'b0);

    add_vec(32'h0000_0000, 16'd4,   1'b1, 1, 1'b0, mk(32'h0, 2'b01, 12'd4, 1'b1), z, z);
    add_vec(32'h0000_01F8, 16'd10,  1'b0, 2, 1'b0, mk(32'hFC, 2'b01, 12'd4, 1'b0),
            mk(32'h100, 2'b01, 12'd6, 1'b0), z);
    add_vec(32'h0000_0000, 16'd600, 1'b1, 3, 1'b0, mk(32'h0, 2'b01, 12'd256, 1'b1),
            mk(32'h100, 2'b01, 12'd256, 1'b1), mk(32'h200, 2'b01, 12'd88, 1'b1));
    add_vec(32'h007F_FFFC, 16'd4,   1'b0, 2, 1'b0, mk(32'h3FFFFE, 2'b01, 12'd2, 1'b0),
            mk(32'h0, 2'b10, 12'd2, 1'b0), z);
    add_vec(32'h0100_0000, 16'd4,   1'b0, 0, 1'b1, z, z, z);
    add_vec(32'h0000_0003, 16'd4,   1'b0, 0, 1'b1, z, z, z);
    add_vec(32'h00FF_FFFC, 16'd4,   1'b1, 1, 1'b1, mk(32'h3FFFFE, 2'b10, 12'd2, 1'b1), z, z);
    add_vec(32'h0000_0100, 16'd0,   1'b0, 0, 1'b0, z, z, z);
    add_vec(32'h0080_0200, 16'd3,   1'b1, 1, 1'b0, mk(32'h100, 2'b10, 12'd3, 1'b1), z, z);
    add_vec(32'h0000_01FE, 16'd1,   1'b0, 1, 1'b0, mk(32'hFF, 2'b01, 12'd1, 1'b0), z, z);

    bus.req_valid_i   = 1'b0;
    bus.req_addr_i    = 32'd0;
    bus.req_len_i     = 16'd0;
    bus.req_write_i   = 1'b0;
    bus.trans_ready_i = 1'b1;

    // Reset state.
    #2 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_valid", 32'(bus.trans_valid_o), 32'd0);
    check("rst_addr",  bus.trans_address_o, 32'd0);
    check("rst_cs",    32'(bus.trans_cs_o), 32'd0);
    check("rst_burst", 32'(bus.trans_burst_o), 32'd0);
    check("rst_done",  32'(bus.done_o), 32'd0);
    check("rst_error", 32'(bus.error_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vq[k]) run_vec(vq[k]);

    // Backpressure: the chunk must hold steady while the PHY stalls.
    bus.trans_ready_i = 1'b0;
    exp_q.push_back(mk(32'h40, 2'b01, 12'd8, 1'b1));
    drive_req(32'h0000_0080, 16'd8, 1'b1);
    g = 0;
    while (!bus.trans_valid_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("bp_valid_seen", 32'(bus.trans_valid_o), 32'd1);
    snap = mk(bus.trans_address_o, bus.trans_cs_o, bus.trans_burst_o, bus.trans_write_o);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(bus.trans_valid_o), 32'd1);
      check("bp_addr_hold",  bus.trans_address_o, snap.word);
      check("bp_burst_hold", 32'(bus.trans_burst_o), 32'(snap.burst));
      check("bp_cs_hold",    32'(bus.trans_cs_o), 32'(snap.cs));
      check("bp_done_low",   32'(bus.done_o), 32'd0);
    end
    bus.trans_ready_i = 1'b1;
    compare_chunk(exp_q.pop_front());
    @(negedge clk);
    check("bp_done", 32'(bus.done_o), 32'd1);
    check("bp_valid_drop", 32'(bus.trans_valid_o), 32'd0);
    @(negedge clk);

    // Asynchronous reset while a chunk is offered.
    bus.trans_ready_i = 1'b0;
    drive_req(32'h0000_0000, 16'd20, 1'b0);
    g = 0;
    while (!bus.trans_valid_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("ar_valid_seen", 32'(bus.trans_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid_drop", 32'(bus.trans_valid_o), 32'd0);
    check("ar_ready",      32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.trans_ready_i = 1'b1;
    @(negedge clk);
    check("ar_ready_after", 32'(bus.req_ready_o), 32'd1);
    check("ar_valid_after", 32'(bus.trans_valid_o), 32'd0);
    check("ar_done_after",  32'(bus.done_o), 32'd0);
    run_vec(vq[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
